// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM waveform sequencer.
package pwm_pkg;

  localparam int PWM_DATA_W  = 12;
  localparam int PWM_ADDR_W  = 10;
  localparam int PWM_DWELL_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    ARMED   = 3'd3,
    LAST    = 3'd4
  } pwm_seq_state_t;

endpackage

// File: rtl/pwm_seq_dwell.sv
// Remaining-periods counter for the sample currently on the PWM output.
module pwm_seq_dwell
  import pwm_pkg::*;
#(
  parameter int DWELL_W = PWM_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] dwell_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_rem <= '0;
    end else if (clr) begin
      dwell_rem <= '0;
    end else if (load) begin
      dwell_rem <= load_val;
    end else if (dec && (dwell_rem != '0)) begin
      dwell_rem <= dwell_rem - DWELL_W'(1);
    end
  end

  assign zero = (dwell_rem == '0);

endmodule

// File: rtl/pwm_sequencer.sv
// Plays duty samples from a 1-cycle-latency ROM into a PWM compare register,
// updating only on PWM period boundaries.
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter int DATA_W  = PWM_DATA_W,
  parameter int ADDR_W  = PWM_ADDR_W,
  parameter int DWELL_W = PWM_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [ADDR_W-1:0]  seq_len,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               period_end,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  duty,
  output logic               duty_load,
  output logic               busy,
  output logic               done,
  output logic               underrun
);

  function automatic logic [DWELL_W-1:0] dwell_clamp(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  pwm_seq_state_t     state;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  len_q;
  logic               loop_q;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DATA_W-1:0]  pending;
  logic               stop_pend;
  logic               dwell_zero;
  logic               dwell_clr;
  logic               dwell_load;
  logic               dwell_dec;
  logic               at_last;
  logic               start_ok;

  assign start_ok = start && !stop && (seq_len != '0);
  assign at_last  = (idx == (len_q - ADDR_W'(1)));
  assign rom_en   = (state == FETCH);
  assign rom_addr = idx;
  assign busy     = (state != IDLE);

  // A stop boundary ends playback outright, so it never reloads the dwell count.
  always_comb begin
    dwell_clr  = (state == IDLE);
    dwell_load = (state == ARMED) && period_end && dwell_zero && !stop_pend;
    dwell_dec  = busy && period_end;
  end

  pwm_seq_dwell #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clr      (dwell_clr),
    .load     (dwell_load),
    .load_val (dwell_eff - DWELL_W'(1)),
    .dec      (dwell_dec),
    .zero     (dwell_zero)
  );

  // Configuration and captured sample: data only, no reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start_ok) begin
      len_q     <= seq_len;
      loop_q    <= loop_en;
      dwell_eff <= dwell_clamp(dwell);
    end
    if (state == CAPTURE) begin
      pending <= rom_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      duty      <= '0;
      duty_load <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      duty_load <= 1'b0;
      done      <= 1'b0;
      if (state == IDLE) begin
        if (start_ok) begin
          state     <= FETCH;
          idx       <= '0;
          underrun  <= 1'b0;
          stop_pend <= 1'b0;
        end
      end else begin
        if (stop) begin
          stop_pend <= 1'b1;
        end
        if (period_end && stop_pend) begin
          duty      <= '0;
          duty_load <= 1'b1;
          done      <= 1'b1;
          stop_pend <= 1'b0;
          state     <= IDLE;
        end else begin
          case (state)
            FETCH: begin
              state <= CAPTURE;
              if (period_end && dwell_zero) underrun <= 1'b1;
            end
            CAPTURE: begin
              state <= ARMED;
              if (period_end && dwell_zero) underrun <= 1'b1;
            end
            ARMED: begin
              if (period_end && dwell_zero) begin
                duty      <= pending;
                duty_load <= 1'b1;
                if (at_last && !loop_q) begin
                  state <= LAST;
                end else begin
                  idx   <= at_last ? '0 : idx + ADDR_W'(1);
                  state <= FETCH;
                end
              end
            end
            LAST: begin
              if (period_end && dwell_zero) begin
                duty      <= '0;
                duty_load <= 1'b1;
                done      <= 1'b1;
                state     <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer with a ROM[i]=100*i model and a period_end generator.
module tb_pwm_sequencer;
  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 10;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               loop_en;
  logic [ADDR_W-1:0]  seq_len;
  logic [DWELL_W-1:0] dwell;
  logic               period_end;
  logic               rom_en;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;
  logic [DATA_W-1:0]  duty;
  logic               duty_load;
  logic               busy;
  logic               done;
  logic               underrun;

  int checks   = 0;
  int failures = 0;
  int ld_q[$];
  int ld_pe[$];
  int exp_q[$];
  int pe_seen  = 0;
  int done_cnt = 0;
  bit pe_on    = 1'b0;
  int pe_per   = 10;
  int pe_cnt   = 0;

  pwm_sequencer #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .seq_len    (seq_len),
    .dwell      (dwell),
    .period_end (period_end),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .duty       (duty),
    .duty_load  (duty_load),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= 12'(100 * int'(rom_addr));
  end

  // period_end pulse generator, one cycle wide every pe_per cycles
  initial begin
    period_end = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!pe_on) begin
        pe_cnt     = 0;
        period_end = 1'b0;
      end else if (pe_cnt == pe_per - 1) begin
        pe_cnt     = 0;
        period_end = 1'b1;
      end else begin
        pe_cnt     = pe_cnt + 1;
        period_end = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (period_end) pe_seen++;
    if (duty_load) begin
      ld_q.push_back(int'(duty));
      ld_pe.push_back(pe_seen);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input int len, input int dw, input bit lp);
    seq_len = ADDR_W'(len);
    dwell   = DWELL_W'(dw);
    loop_en = lp;
    start   = 1'b1;
    cyc(1);
    start   = 1'b0;
  endtask

  task automatic wait_loads(input int n, input int budget);
    int k = 0;
    while (ld_q.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    if (ld_q.size() < n) chk("tmo_loads", ld_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      cyc(1);
      k++;
    end
    if (busy) chk("tmo_idle", busy, 0);
    cyc(1);
  endtask

  task automatic check_seq(input string tag, input int b, input int dexp);
    chk({tag, "_n"}, ld_q.size() - b, exp_q.size());
    for (int i = 0; i < exp_q.size() && b + i < ld_q.size(); i++) begin
      chk($sformatf("%s_v%0d", tag, i), ld_q[b+i], exp_q[i]);
      if (dexp > 0 && i > 0)
        chk($sformatf("%s_hold%0d", tag, i), ld_pe[b+i] - ld_pe[b+i-1], dexp);
    end
  endtask

  initial begin
    int b;
    int d0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    seq_len = '0; dwell = '0;
    cyc(3);
    chk("rst_duty", duty, 0);
    chk("rst_load", duty_load, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    cyc(2);

    // basic one-shot, dwell 2
    b = ld_q.size(); d0 = done_cnt; pe_per = 10;
    kick(4, 2, 1'b0);
    pe_on = 1'b1;
    wait_idle(300);
    pe_on = 1'b0;
    exp_q = {0, 100, 200, 300, 0};
    check_seq("oneshot", b, 2);
    chk("oneshot_done", done_cnt - d0, 1);
    chk("oneshot_busy", busy, 0);
    cyc(3);

    // loop wrap, dwell 1, seven periods
    b = ld_q.size(); d0 = done_cnt;
    kick(3, 1, 1'b1);
    pe_on = 1'b1;
    wait_loads(b + 7, 200);
    exp_q = {0, 100, 200, 0, 100, 200, 0};
    check_seq("loop", b, 1);
    chk("loop_nodone", done_cnt - d0, 0);
    chk("loop_busy", busy, 1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    wait_idle(100);
    pe_on = 1'b0;
    cyc(3);

    // dwell 0 behaves as dwell 1
    b = ld_q.size(); d0 = done_cnt;
    kick(4, 0, 1'b0);
    pe_on = 1'b1;
    wait_idle(200);
    pe_on = 1'b0;
    exp_q = {0, 100, 200, 300, 0};
    check_seq("dwell0", b, 1);
    chk("dwell0_done", done_cnt - d0, 1);
    cyc(3);

    // stop three cycles into sample 1
    b = ld_q.size(); d0 = done_cnt;
    kick(4, 5, 1'b0);
    pe_on = 1'b1;
    wait_loads(b + 2, 200);
    cyc(3);
    stop = 1'b1; cyc(1); stop = 1'b0;
    wait_idle(100);
    exp_q = {0, 100, 0};
    check_seq("stop", b, 0);
    if (ld_q.size() >= b + 3) chk("stop_next_pe", ld_pe[b+2] - ld_pe[b+1], 1);
    chk("stop_done", done_cnt - d0, 1);
    chk("stop_busy", busy, 0);
    chk("stop_duty", duty, 0);
    cyc(40);
    chk("stop_noload", ld_q.size() - b, 3);
    pe_on = 1'b0;
    cyc(3);

    // underrun with period_end every 2 cycles
    b = ld_q.size(); pe_per = 2;
    kick(4, 1, 1'b0);
    pe_on = 1'b1;
    wait_idle(300);
    pe_on = 1'b0;
    exp_q = {0, 100, 200, 300, 0};
    check_seq("urun", b, 0);
    chk("urun_flag", underrun, 1);
    cyc(3);

    // new start clears underrun; then reset while ARMED with duty=100
    b = ld_q.size(); pe_per = 10;
    kick(3, 1, 1'b1);
    cyc(1);
    chk("urun_clr", underrun, 0);
    pe_on = 1'b1;
    wait_loads(b + 2, 100);
    cyc(4);
    chk("pre_rst_duty", duty, 100);
    chk("pre_rst_addr", rom_addr, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_duty", duty, 0);
    chk("arst_load", duty_load, 0);
    chk("arst_rom_en", rom_en, 0);
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    pe_on = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // edge starts: zero length, and start with stop
    d0 = done_cnt;
    kick(0, 2, 1'b0);
    cyc(3);
    chk("len0_busy", busy, 0);
    seq_len = ADDR_W'(4); dwell = DWELL_W'(1);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    cyc(3);
    chk("startstop_busy", busy, 0);
    chk("edge_nodone", done_cnt - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
- Controller that plays a duty-cycle waveform from a sample ROM into a PWM channel.
- Fetches samples over a 1-cycle-latency ROM port and holds each sample for a programmable number of PWM periods.
- Presents new duty values only on PWM period boundaries, which gives glitch-free updates.
- Sits between the waveform table (sine ROM) and the PWM output stage. Supports one-shot and loop playback, plus stop.

Parameters:
- DATA_W, 12, duty sample width; matches ROM word and PWM compare width.
- ADDR_W, 10, sample ROM address width.
- DWELL_W, 16, width of the dwell count (PWM periods per sample).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins playback when idle.
- stop  in  1  single-cycle pulse; ends playback at the next period boundary.
- loop_en  in  1  1 = wrap to sample 0 after the last sample; sampled at start.
- seq_len  in  ADDR_W  number of samples; sampled at start.
- dwell  in  DWELL_W  PWM periods per sample; sampled at start; 0 is treated as 1.
- period_end  in  1  single-cycle pulse from the PWM stage at its period wrap.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  DATA_W  valid the cycle after rom_en.
- duty  out  DATA_W  duty value to the PWM compare register.
- duty_load  out  1  1-cycle strobe, coincident with duty changing.
- busy  out  1  high in any non-IDLE state.
- done  out  1  1-cycle pulse when playback finishes or stops.
- underrun  out  1  sticky; set when a boundary arrives with no sample ready; cleared by start.

Behaviour:
- Reset values: duty=0, duty_load=0, rom_en=0, rom_addr=0, busy=0, done=0, underrun=0, state=IDLE. Reset mid-playback aborts immediately.
- States: IDLE, FETCH, CAPTURE, ARMED, LAST.
- IDLE:
  - On start with seq_len!=0 and stop=0: latch len, loop, dwell_eff=max(dwell,1); idx=0; dwell_rem=0; underrun=0; go to FETCH.
  - start with seq_len==0 is ignored. start together with stop: stop wins, stay IDLE.
- FETCH: rom_en=1, rom_addr=idx for one cycle; go to CAPTURE.
- CAPTURE: pending<=rom_data; go to ARMED. Fetch latency is 2 cycles.
- period_end in FETCH, CAPTURE, ARMED or LAST:
  - If dwell_rem!=0: dwell_rem decrements.
  - If dwell_rem==0 in ARMED:
    - duty<=pending, duty_load=1 next cycle, dwell_rem<=dwell_eff-1.
    - If idx==len-1 and !loop: go to LAST.
    - Else: idx<=(idx==len-1)?0:idx+1, go to FETCH.
  - If dwell_rem==0 in FETCH or CAPTURE: duty holds, underrun<=1, and the load happens at the next boundary after ARMED is reached.
- LAST: on period_end with dwell_rem==0: duty<=0, duty_load=1, done=1, go to IDLE.
- stop while busy:
  - Sets stop_pend.
  - At the next period_end, regardless of dwell_rem: duty<=0, duty_load=1, done=1, go to IDLE.
  - An in-flight ROM read is discarded.
- start while busy is ignored.
- First sample loads at the first period_end after ARMED is reached.
- Each sample is on the output for exactly dwell_eff periods.
- period_end pulses must be ≥3 cycles apart; closer spacing is legal but causes underrun.
- Index arithmetic is ADDR_W-bit. Wrap is by compare to len-1, never by overflow, so len=2^ADDR_W-1 is the maximum.

Decomposition:
- Package pwm_pkg holds:
  - the state enum (pwm_seq_state_t: IDLE/FETCH/CAPTURE/ARMED/LAST);
  - default widths PWM_DATA_W=12, PWM_ADDR_W=10, PWM_DWELL_W=16.
- One sub-module is natural: pwm_seq_dwell, the dwell_rem load/decrement/zero-flag counter.
- Everything else lives in pwm_sequencer.

Test Plan:
- Basic one-shot:
  - Setup: ROM[i]=100*i, seq_len=4, dwell=2, loop_en=0, period_end every 10 cycles.
  - Required: duty sequence 0,100,200,300, each held 2 periods; then duty=0 with done pulse; busy low afterwards; 5 duty_load strobes total.
- Loop wrap:
  - Setup: seq_len=3, dwell=1, loop_en=1, run 7 periods.
  - Required: duty 0,100,200,0,100,200,0; no done pulse; idx returns to 0 after 2.
- dwell=0:
  - Setup: same as the basic one-shot but dwell=0.
  - Required: behaves as dwell=1; each sample is held exactly 1 period.
- Stop mid-sample:
  - Setup: seq_len=4, dwell=5; assert stop 3 cycles into sample 1's dwell.
  - Required: at the next period_end, duty=0, done=1, busy=0; later period_end pulses cause no load.
- Underrun:
  - Setup: period_end every 2 cycles, dwell=1.
  - Required: underrun=1; samples still appear in order with no sample skipped; a later start clears underrun.
- Reset and edge starts:
  - Reset asserted in ARMED: immediate return to all reset values.
  - start with seq_len=0: busy stays 0.
  - start and stop in the same cycle: busy stays 0.
